uart_rx_sample_ctrl: RTL and testbench

Oversampling receive controller that sequences bit-center sampling of the UART serial line for the slave-side monitor path. It generates the baud oversample tick and detects start bits, then walks a frame FSM (start, data, parity, stop). It delivers each assembled character with parity, framing and break status as a single-cycle strobe to the slave monitor BFM. All frame timing is owned here, so the monitor only consumes completed frames.

---
 rtl/uart_rx_ctrl_pkg.sv | 33 +++
 rtl/uart_baud_tick_gen.sv | 38 +++
 rtl/uart_rx_sample_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_sample_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types for the UART receive sample controller: FSM state encoding,
// completed-frame status record and the data-bits clamp helper.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Wide enough for any data_bits value the 4-bit config field can express.
  localparam int STATUS_DATA_W = 15;

  typedef struct packed {
    logic [STATUS_DATA_W-1:0] data;
    logic                     parity_err;
    logic                     framing_err;
    logic                     break_det;
  } frame_status_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'd5)
      return 4'd5;
    else if (req > max_bits)
      return max_bits;
    else
      return req;
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: down-counter that pulses every max(baud_div,1)
// clocks and is held in reload while restart is high.
module uart_baud_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] reload;

  always_comb begin
    reload = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
    tick   = 1'b0;
    cnt_d  = cnt_q;
    if (restart) begin
      cnt_d = reload;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_sample_ctrl.sv
// UART receive controller: synchronizes rx, detects start edges, samples each
// bit at its center and emits a one-cycle strobe with the assembled frame.
module uart_rx_sample_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 8,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_WIDTH-1:0]     baud_div,
  input  logic [3:0]               data_bits,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     two_stop,
  input  logic                     rx,
  output logic                     busy,
  output logic                     frame_valid,
  output logic [MAX_DATA_BITS-1:0] frame_data,
  output logic                     parity_err,
  output logic                     framing_err,
  output logic                     break_det
);

  localparam int                SCNT_W  = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] HALF_M1 = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] OS_M1   = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        MAX_DB  = 4'(MAX_DATA_BITS);

  logic                     rx_meta_q, rx_meta_d;
  logic                     rx_s_q, rx_s_d;
  logic                     rx_prev_q, rx_prev_d;
  rx_state_e                state_q, state_d;
  logic [SCNT_W-1:0]        scnt_q, scnt_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic                     stop_cnt_q, stop_cnt_d;
  logic [3:0]               db_q, db_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic                     two_stop_q, two_stop_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_acc_q, par_acc_d;
  logic                     par_bit_q, par_bit_d;
  logic                     stop0_q, stop0_d;
  logic                     fe_acc_q, fe_acc_d;
  logic                     frame_valid_q, frame_valid_d;
  frame_status_t            status_q, status_d;

  logic tick;
  logic fall;
  logic center;
  logic fe_next;
  logic first_stop;

  uart_baud_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart  (state_q == ST_IDLE),
    .baud_div (baud_div),
    .tick     (tick)
  );

  always_comb begin
    rx_meta_d     = rx;
    rx_s_d        = rx_meta_q;
    rx_prev_d     = rx_s_q;
    fall          = rx_prev_q & ~rx_s_q;
    center        = tick && (scnt_q == OS_M1);
    fe_next       = fe_acc_q | ~rx_s_q;
    first_stop    = stop_cnt_q ? stop0_q : rx_s_q;

    state_d       = state_q;
    scnt_d        = scnt_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    db_d          = db_q;
    par_en_d      = par_en_q;
    par_odd_d     = par_odd_q;
    two_stop_d    = two_stop_q;
    shift_d       = shift_q;
    par_acc_d     = par_acc_q;
    par_bit_d     = par_bit_q;
    stop0_d       = stop0_q;
    fe_acc_d      = fe_acc_q;
    frame_valid_d = 1'b0;
    status_d      = status_q;

    // Bit-period counter shared by DATA/PARITY/STOP; START uses the half period.
    if (state_q != ST_IDLE && state_q != ST_START && tick)
      scnt_d = center ? '0 : scnt_q + SCNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        scnt_d = '0;
        if (enable && fall) begin
          db_d       = clamp_data_bits(data_bits, MAX_DB);
          par_en_d   = parity_en;
          par_odd_d  = parity_odd;
          two_stop_d = two_stop;
          shift_d    = '0;
          par_acc_d  = 1'b0;
          par_bit_d  = 1'b0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          stop0_d    = 1'b1;
          fe_acc_d   = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (scnt_q == HALF_M1) begin
            scnt_d  = '0;
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (center) begin
          for (int i = 0; i < MAX_DATA_BITS; i++)
            if (bit_cnt_q == 4'(i)) shift_d[i] = rx_s_q;
          par_acc_d = par_acc_q ^ rx_s_q;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == db_q - 4'd1)
            state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (center) begin
          par_bit_d = rx_s_q;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (center) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop0_d    = rx_s_q;
            fe_acc_d   = fe_next;
            stop_cnt_d = 1'b1;
          end else begin
            frame_valid_d        = 1'b1;
            status_d.data        = STATUS_DATA_W'(shift_q);
            status_d.parity_err  = par_en_q & ((par_acc_q ^ par_bit_q) != par_odd_q);
            status_d.framing_err = fe_next;
            status_d.break_det   = (shift_q == '0) & ~(par_en_q & par_bit_q) & ~first_stop;
            state_d              = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling aborts the frame silently, even on the final stop sample.
    if (!enable) begin
      state_d       = ST_IDLE;
      frame_valid_d = 1'b0;
      status_d      = status_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      scnt_q        <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      db_q          <= 4'd5;
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      two_stop_q    <= 1'b0;
      shift_q       <= '0;
      par_acc_q     <= 1'b0;
      par_bit_q     <= 1'b0;
      stop0_q       <= 1'b1;
      fe_acc_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      status_q      <= '0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_s_q        <= rx_s_d;
      rx_prev_q     <= rx_prev_d;
      state_q       <= state_d;
      scnt_q        <= scnt_d;
      bit_cnt_q     <= bit_cnt_d;
      stop_cnt_q    <= stop_cnt_d;
      db_q          <= db_d;
      par_en_q      <= par_en_d;
      par_odd_q     <= par_odd_d;
      two_stop_q    <= two_stop_d;
      shift_q       <= shift_d;
      par_acc_q     <= par_acc_d;
      par_bit_q     <= par_bit_d;
      stop0_q       <= stop0_d;
      fe_acc_q      <= fe_acc_d;
      frame_valid_q <= frame_valid_d;
      status_q      <= status_d;
    end
  end

  if (MAX_DATA_BITS < STATUS_DATA_W) begin : g_pad
    logic unused_status_msbs;
    assign unused_status_msbs = |status_q.data[STATUS_DATA_W-1:MAX_DATA_BITS];
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_valid = frame_valid_q;
  assign frame_data  = status_q.data[MAX_DATA_BITS-1:0];
  assign parity_err  = status_q.parity_err;
  assign framing_err = status_q.framing_err;
  assign break_det   = status_q.break_det;

endmodule

// File: tb/tb_uart_rx_sample_ctrl.sv
// Directed bench for uart_rx_sample_ctrl: 16x oversample, baud_div=4
// (64 clk per bit), frames driven bit by bit on rx.
module tb_uart_rx_sample_ctrl;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [15:0] baud_div;
  logic [3:0] data_bits;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       rx;
  logic       busy;
  logic       frame_valid;
  logic [7:0] frame_data;
  logic       parity_err;
  logic       framing_err;
  logic       break_det;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_count = 0;
  int fv_cyc = 0;
  logic [7:0] cap_data = '0;
  logic cap_pe = 1'b0, cap_fe = 1'b0, cap_bd = 1'b0;
  int t_start = 0;
  logic busy_mid = 1'b0;
  int n0;

  uart_rx_sample_ctrl #(
    .OVERSAMPLE    (16),
    .MAX_DATA_BITS (8),
    .DIV_WIDTH     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .two_stop    (two_stop),
    .rx          (rx),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .break_det   (break_det)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count <= fv_count + 1;
      fv_cyc   <= cyc;
      cap_data <= frame_data;
      cap_pe   <= parity_err;
      cap_fe   <= framing_err;
      cap_bd   <= break_det;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nd, input logic has_par,
                            input logic pbit, input int nstop, input logic s2);
    t_start = cyc;
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(posedge clk);
    #1 busy_mid = busy;
    repeat (BIT_CLK / 2) @(posedge clk);
    #1;
    for (int i = 0; i < nd; i++) bit_out(d[i]);
    if (has_par) bit_out(pbit);
    bit_out(1'b1);
    if (nstop == 2) bit_out(s2);
    bit_out(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    baud_div = 16'd4;
    data_bits = 4'd8;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_data", frame_data, 0);
    check("rst_pe", parity_err, 0);
    check("rst_fe", framing_err, 0);
    check("rst_bd", break_det, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // 8N1, 0xA5
    n0 = fv_count;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    check("8n1_count", fv_count - n0, 1);
    check("8n1_data", cap_data, 8'hA5);
    check("8n1_pe", cap_pe, 0);
    check("8n1_fe", cap_fe, 0);
    check("8n1_bd", cap_bd, 0);
    check("8n1_latency_ok", 32'(((fv_cyc - t_start) >= 610) && ((fv_cyc - t_start) <= 612)), 1);
    check("8n1_busy_mid", busy_mid, 1);
    check("8n1_busy_after", busy, 0);

    // 7E1, 0x35 with good then bad parity
    data_bits = 4'd7;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    n0 = fv_count;
    send_frame(8'h35, 7, 1'b1, 1'b0, 1, 1'b1);
    check("7e1_good_count", fv_count - n0, 1);
    check("7e1_good_data", cap_data, 8'h35);
    check("7e1_good_pe", cap_pe, 0);
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);
    check("7e1_bad_count", fv_count - n0, 2);
    check("7e1_bad_data", cap_data, 8'h35);
    check("7e1_bad_pe", cap_pe, 1);

    // 8N2, second stop bit low
    data_bits = 4'd8;
    parity_en = 1'b0;
    two_stop = 1'b1;
    n0 = fv_count;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 2, 1'b0);
    check("8n2_count", fv_count - n0, 1);
    check("8n2_data", cap_data, 8'h5A);
    check("8n2_fe", cap_fe, 1);
    check("8n2_pe", cap_pe, 0);
    check("8n2_bd", cap_bd, 0);

    // Break: 12 bit times low, 8N1
    two_stop = 1'b0;
    n0 = fv_count;
    rx = 1'b0;
    repeat (12 * BIT_CLK) @(posedge clk);
    #1 rx = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check("brk_count", fv_count - n0, 1);
    check("brk_data", cap_data, 0);
    check("brk_fe", cap_fe, 1);
    check("brk_bd", cap_bd, 1);
    check("brk_busy_after", busy, 0);

    // Quarter-bit glitch on idle line
    n0 = fv_count;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1 busy_mid = busy;
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_busy_mid", busy_mid, 1);
    check("glitch_busy_after", busy, 0);
    check("glitch_count", fv_count - n0, 0);

    // Reset pulse mid-DATA, then a clean 0x3C
    n0 = fv_count;
    rx = 1'b0;
    repeat (3 * BIT_CLK) @(posedge clk);
    #1 busy_mid = busy;
    rx = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rstmid_busy_before", busy_mid, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_fe", framing_err, 0);
    check("rstmid_bd", break_det, 0);
    check("rstmid_data", frame_data, 0);
    repeat (100) @(posedge clk);
    #1;
    check("rstmid_no_strobe", fv_count - n0, 0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
    check("post_rst_count", fv_count - n0, 1);
    check("post_rst_data", cap_data, 8'h3C);
    check("post_rst_pe", cap_pe, 0);
    check("post_rst_fe", cap_fe, 0);
    check("post_rst_bd", cap_bd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
